// File: rtl/imem_loader.sv
// Boot-time instruction loader: turns a length-prefixed byte stream into
// sequential n-bit writes on the imem write port, holding the CPU while busy.
module imem_loader #(
    parameter int n = 16,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         mem_we,
    output logic [r-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [r:0]   word_count
);

    localparam int BYTES = n / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DEPTH = 1 << r;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [7:0]     len_reg;
    logic [r-1:0]   idx_reg;
    logic [BW-1:0]  byte_cnt_reg;
    logic [n-1:0]   asm_reg;
    logic [r-1:0]   mem_addr_reg;
    logic [n-1:0]   mem_wdata_reg;
    logic           err_reg;
    logic [r:0]     word_count_reg;

    logic [n+7:0]   asm_cat;
    logic [n-1:0]   asm_next;
    logic           last_byte;
    logic           last_word;
    logic           too_long;

    // New byte enters at the LSB, so the first byte of a word ends up in the MSB.
    assign asm_cat   = {asm_reg, in_byte};
    assign asm_next  = asm_cat[n-1:0];
    assign last_byte = (byte_cnt_reg == BW'(BYTES - 1));
    assign last_word = (32'(idx_reg) == (32'(len_reg) - 32'd1));
    assign too_long  = (32'(in_byte) > 32'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_byte == 8'd0) begin
                        state_next = DONE;
                    end else if (too_long) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = last_word ? DONE : DATA;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_reg        <= '0;
            idx_reg        <= '0;
            byte_cnt_reg   <= '0;
            asm_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            err_reg        <= 1'b0;
            word_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        err_reg        <= 1'b0;
                        word_count_reg <= '0;
                    end
                end
                LEN: begin
                    if (in_valid) begin
                        if (too_long) begin
                            err_reg <= 1'b1;
                        end else begin
                            len_reg <= in_byte;
                        end
                        idx_reg      <= '0;
                        byte_cnt_reg <= '0;
                        asm_reg      <= '0;
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        asm_reg <= asm_next;
                        if (last_byte) begin
                            // Present the finished word on the port for the WRITE cycle.
                            byte_cnt_reg  <= '0;
                            mem_wdata_reg <= asm_next;
                            mem_addr_reg  <= idx_reg;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + BW'(1);
                        end
                    end
                end
                WRITE: begin
                    word_count_reg <= word_count_reg + (r+1)'(1);
                    if (!last_word) begin
                        idx_reg <= idx_reg + r'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign err        = err_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams length-prefixed byte sessions and
// checks the imem writes, status outputs and length/reset corner cases.
module tb_imem_loader;

    localparam int N = 16;
    localparam int R = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_ready;
    logic         mem_we;
    logic [R-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         busy;
    logic         done;
    logic         err;
    logic [R:0]   word_count;

    int nvec = 0;
    int nerr = 0;
    int sess_we = 0;
    int done_count = 0;
    int last_addr = 0;
    logic [N-1:0] tb_mem [0:(1<<R)-1];

    imem_loader #(.n(N), .r(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Write monitor: the bench-side imem plus per-write address/ready checks.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            $display("write addr=%0d data=%h", mem_addr, mem_wdata);
            chk("wr_in_ready", 32'(in_ready), 32'd0);
            chk("wr_addr_seq", 32'(mem_addr), 32'(sess_we));
            tb_mem[mem_addr] = mem_wdata;
            last_addr = int'(mem_addr);
            sess_we++;
        end
        if (done === 1'b1) begin
            done_count++;
        end
    end

    task automatic new_session();
        sess_we = 0;
        done_count = 0;
        for (int i = 0; i < (1<<R); i++) tb_mem[i] = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (in_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("byte %h accepted=%0d", b, acc);
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL byte_timeout: byte %h never accepted, expected acceptance", b);
        end
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
        if (busy !== 1'b0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: busy still %b after 200 cycles, expected 0", tag, busy);
        end
    endtask

    task automatic send_basic(input bit gaps);
        logic [7:0] s [0:6];
        s = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        for (int i = 0; i < 7; i++) send_byte(s[i], gaps ? int'($urandom_range(3, 1)) : 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic load, in_valid held high
        new_session();
        do_start();
        chk("basic_busy", 32'(busy), 32'd1);
        send_basic(1'b0);
        wait_idle("basic_idle");
        chk("basic_we_count", 32'(sess_we), 32'd3);
        chk("basic_w0", 32'(tb_mem[0]), 32'h1234);
        chk("basic_w1", 32'(tb_mem[1]), 32'hABCD);
        chk("basic_w2", 32'(tb_mem[2]), 32'h0001);
        chk("basic_done", 32'(done_count), 32'd1);
        chk("basic_word_count", 32'(word_count), 32'd3);
        chk("basic_err", 32'(err), 32'd0);

        // Same stream with gaps between bytes
        new_session();
        do_start();
        send_basic(1'b1);
        wait_idle("bp_idle");
        chk("bp_we_count", 32'(sess_we), 32'd3);
        chk("bp_w0", 32'(tb_mem[0]), 32'h1234);
        chk("bp_w1", 32'(tb_mem[1]), 32'hABCD);
        chk("bp_w2", 32'(tb_mem[2]), 32'h0001);
        chk("bp_done", 32'(done_count), 32'd1);
        chk("bp_word_count", 32'(word_count), 32'd3);

        // L=0: done the cycle after the length byte
        new_session();
        do_start();
        send_byte(8'h00, 0);
        chk("l0_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("l0_done_gone", 32'(done), 32'd0);
        chk("l0_busy", 32'(busy), 32'd0);
        chk("l0_we_count", 32'(sess_we), 32'd0);
        chk("l0_word_count", 32'(word_count), 32'd0);

        // L=33 exceeds depth
        new_session();
        do_start();
        send_byte(8'h21, 0);
        chk("l33_err", 32'(err), 32'd1);
        chk("l33_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("l33_err_sticky", 32'(err), 32'd1);
        chk("l33_done", 32'(done_count), 32'd0);
        chk("l33_we_count", 32'(sess_we), 32'd0);

        // L=1 after the error clears err
        new_session();
        do_start();
        chk("l1_err_cleared", 32'(err), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        wait_idle("l1_idle");
        chk("l1_w0", 32'(tb_mem[0]), 32'h00FF);
        chk("l1_we_count", 32'(sess_we), 32'd1);
        chk("l1_word_count", 32'(word_count), 32'd1);
        chk("l1_done", 32'(done_count), 32'd1);

        // Full depth: word k = k
        new_session();
        do_start();
        send_byte(8'h20, 0);
        for (int k = 0; k < 32; k++) begin
            send_byte(8'h00, 0);
            send_byte(8'(k), 0);
        end
        wait_idle("full_idle");
        chk("full_we_count", 32'(sess_we), 32'd32);
        chk("full_last_addr", 32'(last_addr), 32'h1F);
        chk("full_w0", 32'(tb_mem[0]), 32'h0000);
        chk("full_w16", 32'(tb_mem[16]), 32'h0010);
        chk("full_w31", 32'(tb_mem[31]), 32'h001F);
        chk("full_word_count", 32'(word_count), 32'd32);
        chk("full_done", 32'(done_count), 32'd1);
        chk("full_err", 32'(err), 32'd0);

        // Reset after the first byte of the second word
        new_session();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_we_count", 32'(sess_we), 32'd1);
        new_session();
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        wait_idle("post_rst_idle");
        chk("post_rst_w0", 32'(tb_mem[0]), 32'h5566);
        chk("post_rst_we_count", 32'(sess_we), 32'd1);
        chk("post_rst_word_count", 32'(word_count), 32'd1);

        // start pulsed mid-DATA is ignored
        new_session();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        do_start();
        chk("sb_busy", 32'(busy), 32'd1);
        chk("sb_in_ready", 32'(in_ready), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_idle("sb_idle");
        chk("sb_w0", 32'(tb_mem[0]), 32'h0102);
        chk("sb_w1", 32'(tb_mem[1]), 32'h0304);
        chk("sb_we_count", 32'(sess_we), 32'd2);
        chk("sb_word_count", 32'(word_count), 32'd2);
        chk("sb_done", 32'(done_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into n-bit instruction words, MSB byte first.
- Writes each completed word into the imem write port at sequential addresses starting at 0.
- Holds the CPU in hold while loading and reports done/error; sits between the host byte link and imem at boot.

Parameters:
- n, 16, instruction word width in bits; must be a multiple of 8 and at least 8.
- r, 5, imem address width; depth is 2**r words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins a load session; sampled only in IDLE.
- in_valid  input  1  in_byte holds a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  imem write enable, one-cycle pulse per word.
- mem_addr  output  r  imem write address.
- mem_wdata  output  n  imem write data.
- busy  output  1  session in progress; also used as the CPU hold.
- done  output  1  one-cycle pulse when a session completes successfully.
- err  output  1  sticky length error; cleared by the next accepted start.
- word_count  output  r+1  number of words written in the current or last session.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready, mem_we, busy, done and err are 0.
  - mem_addr, mem_wdata and word_count are 0.
  - Byte and word counters and the assembly register are cleared.
  - A reset mid-session aborts the load; no partial word is written.
- Byte transfer: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready is 1 only in LEN and DATA.
- States:
  - IDLE: start=1 clears err and word_count and moves to LEN. busy=0.
  - LEN: the accepted byte is length L, the word count.
    - L=0 goes to DONE.
    - L>2**r sets err=1 and returns to IDLE with no writes and no done.
    - Otherwise the loader latches L and goes to DATA.
  - DATA: accepted bytes shift into the assembly register (new byte enters the LSB, earlier bytes move up).
    - The byte counter wraps at n/8.
    - On acceptance of the (n/8)-th byte, go to WRITE.
  - WRITE: one cycle with in_ready=0 and mem_we=1.
    - mem_addr is the word index; mem_wdata is the assembled word.
    - word_count increments on this edge.
    - If the index equals L-1, go to DONE; otherwise increment the index and go to DATA.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in LEN, DATA, WRITE and DONE.
- start is ignored outside IDLE.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Address never wraps: L=2**r ends at address 2**r-1, and word_count=2**r (hence r+1 bits).
- Latency: the write occurs on the cycle after the last byte of a word is accepted. Minimum session time is 1 + L*(n/8+1) + 1 cycles after start.
- in_valid gaps stall the loader with no state change. A byte presented during WRITE is held by the sender (in_ready=0).

Test Plan:
- Basic load: reset, start, stream 03 12 34 AB CD 00 01 with in_valid held high. Required: mem_we pulses at addr 0=16'h1234, 1=16'hABCD, 2=16'h0001; done pulses once; word_count=3; busy then 0. Bench's imem reads back the same words.
- Backpressure: same stream with in_valid low for 1-3 random cycles between bytes. Required: identical writes and no extra mem_we. in_ready is 0 in each WRITE cycle and no byte is lost.
- Length edge cases:
  - L=0: done one cycle after the length byte, no mem_we, word_count=0.
  - L=33: err=1, busy=0, no done, no mem_we.
  - A following start with L=1 and data 00 FF: err cleared, addr 0=16'h00FF.
- Full depth: L=32 with word k=16'h(k) for k=0..31. Required: last write at addr 5'h1F; word_count=6'd32; no wrap to addr 0.
- Reset mid-load: assert reset after the first byte of the second word. Required: all outputs 0 immediately (asynchronous), no write of the partial word. A new session after release writes from addr 0.
- start while busy: pulse start during DATA. Required: no effect on state, counters or writes.
